// File: rtl/tnew_stage_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : tnew_stage_tracker
//  Purpose  : Tracks {Dst, Tnew} for the E, M and W pipeline stages. From
//             those records it derives the D-stage stall and the D-stage
//             forwarding selects for both source registers.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk                     core clock, rising edge
//    reset                   synchronous reset, active high
//    D_Tnew[1:0]             original Tnew of the D instruction (01 alu, 10 load)
//    D_RegWrite              D instruction writes the GRF
//    D_Dst[4:0]              D instruction destination register
//    D_Rs/D_Rt[4:0]          D instruction source registers
//    D_UseRs/D_UseRt         source register is actually read
//    D_TuseRs/D_TuseRt[1:0]  cycles until the source is needed (0 = D, 1 = E)
//    D_IsMd, MDU_Busy        only with TRACKER_MDU_BUSY_EN: MDU structural hazard
//    Stall                   freeze PC and D, inject a bubble into E
//    FwdRsSel/FwdRtSel[1:0]  00 GRF, 01 from M, 10 from W
//    E/M/W_Tnew[1:0]         tracked per-stage Tnew
//    E/M/W_Dst[4:0]          tracked per-stage destination (0 = no write)
//  Configuration
//    TRACKER_MDU_BUSY_EN     when defined, adds D_IsMd/MDU_Busy and ORs
//                            (D_IsMd & MDU_Busy) into Stall
// ============================================================================
module tnew_stage_tracker (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] D_Tnew,
    input  logic       D_RegWrite,
    input  logic [4:0] D_Dst,
    input  logic [4:0] D_Rs,
    input  logic [4:0] D_Rt,
    input  logic       D_UseRs,
    input  logic       D_UseRt,
    input  logic [1:0] D_TuseRs,
    input  logic [1:0] D_TuseRt,
`ifdef TRACKER_MDU_BUSY_EN
    input  logic       D_IsMd,
    input  logic       MDU_Busy,
`endif
    output logic       Stall,
    output logic [1:0] FwdRsSel,
    output logic [1:0] FwdRtSel,
    output logic [1:0] E_Tnew,
    output logic [1:0] M_Tnew,
    output logic [1:0] W_Tnew,
    output logic [4:0] E_Dst,
    output logic [4:0] M_Dst,
    output logic [4:0] W_Dst
);

    localparam logic [1:0] c_FWD_GRF = 2'b00;
    localparam logic [1:0] c_FWD_M   = 2'b01;
    localparam logic [1:0] c_FWD_W   = 2'b10;

    // Stage records
    logic [4:0] r_e_dst, r_m_dst, r_w_dst;
    logic [1:0] r_e_tnew, r_m_tnew, r_w_tnew;

    // Per-source views: index 0 = rs, index 1 = rt
    logic [4:0] w_src  [2];
    logic       w_use  [2];
    logic [1:0] w_tuse [2];
    logic [1:0] w_fwd  [2];
    logic [1:0] w_conflict;
    logic       w_mdu_stall;

    // Tnew counts down by one per stage and must stop at zero: a bubble or an
    // already-ready result must never wrap to 3 and create a phantom hazard.
    function automatic logic [1:0] sat_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : (t - 2'd1);
    endfunction

    assign w_src[0]  = D_Rs;
    assign w_src[1]  = D_Rt;
    assign w_use[0]  = D_UseRs;
    assign w_use[1]  = D_UseRt;
    assign w_tuse[0] = D_TuseRs;
    assign w_tuse[1] = D_TuseRt;

    generate
        for (genvar i = 0; i < 2; i++) begin : g_src
            // W never appears here: its Tnew is always 0, so it can only
            // forward, never stall.
            assign w_conflict[i] = w_use[i] & (w_src[i] != 5'd0) &
                                   (((r_e_dst == w_src[i]) & (r_e_tnew > w_tuse[i])) |
                                    ((r_m_dst == w_src[i]) & (r_m_tnew > w_tuse[i])));

            // M is checked first so the youngest ready producer wins.
            assign w_fwd[i] = ((w_src[i] != 5'd0) && (r_m_dst == w_src[i]) && (r_m_tnew == 2'd0)) ? c_FWD_M :
                              ((w_src[i] != 5'd0) && (r_w_dst == w_src[i]))                       ? c_FWD_W :
                                                                                                     c_FWD_GRF;
        end
    endgenerate

`ifdef TRACKER_MDU_BUSY_EN
    assign w_mdu_stall = D_IsMd & MDU_Busy;
`else
    assign w_mdu_stall = 1'b0;
`endif

    assign Stall    = (|w_conflict) | w_mdu_stall;
    assign FwdRsSel = w_fwd[0];
    assign FwdRtSel = w_fwd[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_e_dst  <= 5'd0;
            r_e_tnew <= 2'd0;
            r_m_dst  <= 5'd0;
            r_m_tnew <= 2'd0;
            r_w_dst  <= 5'd0;
            r_w_tnew <= 2'd0;
        end else begin
            if (Stall) begin
                // D is held, so E receives a bubble that matches nothing.
                r_e_dst  <= 5'd0;
                r_e_tnew <= 2'd0;
            end else begin
                r_e_dst  <= D_RegWrite ? D_Dst : 5'd0;
                r_e_tnew <= D_Tnew;
            end
            // M and W always advance; a stall only freezes the front end.
            r_m_dst  <= r_e_dst;
            r_m_tnew <= sat_dec(r_e_tnew);
            r_w_dst  <= r_m_dst;
            r_w_tnew <= sat_dec(r_m_tnew);
        end
    end

    assign E_Dst  = r_e_dst;
    assign E_Tnew = r_e_tnew;
    assign M_Dst  = r_m_dst;
    assign M_Tnew = r_m_tnew;
    assign W_Dst  = r_w_dst;
    assign W_Tnew = r_w_tnew;

endmodule
`default_nettype wire

// File: tb/tb_tnew_stage_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tnew_stage_tracker
//  Purpose  : Directed-vector bench for tnew_stage_tracker. Each step drives
//             the D-stage inputs and queues the expected outputs; a monitor
//             on the falling edge pops and compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tnew_stage_tracker;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] D_Tnew;
    logic       D_RegWrite;
    logic [4:0] D_Dst, D_Rs, D_Rt;
    logic       D_UseRs, D_UseRt;
    logic [1:0] D_TuseRs, D_TuseRt;
`ifdef TRACKER_MDU_BUSY_EN
    logic       D_IsMd, MDU_Busy;
`endif
    logic       Stall;
    logic [1:0] FwdRsSel, FwdRtSel;
    logic [1:0] E_Tnew, M_Tnew, W_Tnew;
    logic [4:0] E_Dst, M_Dst, W_Dst;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       stall;
        logic [1:0] frs;
        logic [1:0] frt;
        logic [1:0] etn;
        logic [4:0] edst;
        logic [1:0] mtn;
        logic [4:0] mdst;
        logic [1:0] wtn;
        logic [4:0] wdst;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    tnew_stage_tracker dut (
        .clk        (clk),
        .reset      (reset),
        .D_Tnew     (D_Tnew),
        .D_RegWrite (D_RegWrite),
        .D_Dst      (D_Dst),
        .D_Rs       (D_Rs),
        .D_Rt       (D_Rt),
        .D_UseRs    (D_UseRs),
        .D_UseRt    (D_UseRt),
        .D_TuseRs   (D_TuseRs),
        .D_TuseRt   (D_TuseRt),
`ifdef TRACKER_MDU_BUSY_EN
        .D_IsMd     (D_IsMd),
        .MDU_Busy   (MDU_Busy),
`endif
        .Stall      (Stall),
        .FwdRsSel   (FwdRsSel),
        .FwdRtSel   (FwdRtSel),
        .E_Tnew     (E_Tnew),
        .M_Tnew     (M_Tnew),
        .W_Tnew     (W_Tnew),
        .E_Dst      (E_Dst),
        .M_Dst      (M_Dst),
        .W_Dst      (W_Dst)
    );

    function automatic exp_t mk(input logic s, input logic [1:0] frs, input logic [1:0] frt,
                                input logic [1:0] etn, input logic [4:0] edst,
                                input logic [1:0] mtn, input logic [4:0] mdst,
                                input logic [1:0] wtn, input logic [4:0] wdst);
        exp_t e;
        e.stall = s;   e.frs = frs;   e.frt = frt;
        e.etn = etn;   e.edst = edst;
        e.mtn = mtn;   e.mdst = mdst;
        e.wtn = wtn;   e.wdst = wdst;
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Apply one set of D inputs just after a rising edge, queue the outputs
    // expected during this cycle, then advance to the next cycle.
    task automatic step(input logic rst_v, input logic rw, input logic [1:0] tnew,
                        input logic [4:0] dst, input logic [4:0] rs, input logic urs,
                        input logic [1:0] trs, input logic [4:0] rt, input logic urt,
                        input logic [1:0] trt, input exp_t e);
        reset      = rst_v;
        D_RegWrite = rw;
        D_Tnew     = tnew;
        D_Dst      = dst;
        D_Rs       = rs;
        D_UseRs    = urs;
        D_TuseRs   = trs;
        D_Rt       = rt;
        D_UseRt    = urt;
        D_TuseRt   = trt;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("stall",    int'(Stall),    int'(e.stall));
            chk("fwd_rs",   int'(FwdRsSel), int'(e.frs));
            chk("fwd_rt",   int'(FwdRtSel), int'(e.frt));
            chk("e_tnew",   int'(E_Tnew),   int'(e.etn));
            chk("e_dst",    int'(E_Dst),    int'(e.edst));
            chk("m_tnew",   int'(M_Tnew),   int'(e.mtn));
            chk("m_dst",    int'(M_Dst),    int'(e.mdst));
            chk("w_tnew",   int'(W_Tnew),   int'(e.wtn));
            chk("w_dst",    int'(W_Dst),    int'(e.wdst));
        end
    end

    exp_t z;

    initial begin
        z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        D_RegWrite = 0; D_Tnew = 0; D_Dst = 0;
        D_Rs = 0; D_UseRs = 0; D_TuseRs = 0;
        D_Rt = 0; D_UseRt = 0; D_TuseRt = 0;
`ifdef TRACKER_MDU_BUSY_EN
        D_IsMd = 0; MDU_Busy = 0;
`endif
        repeat (2) @(posedge clk);
        #1;

        // reset held: a reader of $8 sees nothing
        step(1, 0, 0, 0,   8, 1, 1,   8, 1, 1, z);
        // lw $8 enters D
        step(0, 1, 2, 8,   0, 0, 0,   0, 0, 0, z);
        // add $10,$8,$0 (Tuse 1) behind the load: one stall cycle
        step(0, 1, 1, 10,  8, 1, 1,   0, 1, 1, mk(1, 0, 0, 2, 8, 0, 0, 0, 0));
        // load now in M with Tnew 1, bubble in E: no stall, not yet forwardable
        step(0, 1, 1, 10,  8, 1, 1,   0, 1, 1, mk(0, 0, 0, 0, 0, 1, 8, 0, 0));
        // add $11,$8,$10: load reaches W -> rs from W; $10 in E is ready in time
        step(0, 1, 1, 11,  8, 1, 1,  10, 1, 1, mk(0, 2, 0, 1, 10, 0, 0, 0, 8));
        // beq $11,$10 (Tuse 0): $11 still in E -> stall; $10 in M ready -> rt from M
        step(0, 0, 1, 5,  11, 1, 0,  10, 1, 0, mk(1, 0, 1, 1, 11, 0, 10, 0, 0));
        // after the bubble: $11 from M, $10 from W
        step(0, 0, 1, 5,  11, 1, 0,  10, 1, 0, mk(0, 1, 2, 0, 0, 0, 11, 0, 10));
        // non-writing beq entered E as {0,1}; first add $9
        step(0, 1, 1, 9,   0, 0, 0,   0, 0, 0, mk(0, 0, 0, 1, 0, 0, 0, 0, 11));
        // second add $9
        step(0, 1, 1, 9,   0, 0, 0,   0, 0, 0, mk(0, 0, 0, 1, 9, 0, 0, 0, 0));
        step(0, 0, 0, 0,   0, 0, 0,   0, 0, 0, mk(0, 0, 0, 1, 9, 0, 9, 0, 0));
        // $9 in both M and W: M wins
        step(0, 0, 0, 0,   9, 1, 1,   0, 0, 0, mk(0, 1, 0, 0, 0, 0, 9, 0, 9));
        // read of $0 with a producer writing $0
        step(0, 1, 1, 0,   0, 1, 0,   0, 1, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 9));
        step(0, 0, 0, 0,   0, 1, 0,   0, 1, 0, mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
        // lw $8, then reset during the load-use stall
        step(0, 1, 2, 8,   0, 0, 0,   0, 0, 0, z);
        step(1, 1, 1, 10,  8, 1, 1,   0, 0, 0, mk(1, 0, 0, 2, 8, 0, 0, 0, 0));
        step(0, 1, 1, 10,  8, 1, 1,   0, 0, 0, z);
        // drain: non-load goes E 1 -> M 0 -> W 0
        step(0, 0, 0, 0,   0, 0, 0,   0, 0, 0, mk(0, 0, 0, 1, 10, 0, 0, 0, 0));
        step(0, 0, 0, 0,   0, 0, 0,   0, 0, 0, mk(0, 0, 0, 0, 0, 0, 10, 0, 0));
        step(0, 0, 0, 0,   0, 0, 0,   0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 10));
`ifdef TRACKER_MDU_BUSY_EN
        D_IsMd = 1; MDU_Busy = 1;
        step(0, 0, 0, 0,   0, 0, 0,   0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        step(0, 0, 0, 0,   0, 0, 0,   0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        D_IsMd = 0; MDU_Busy = 1;
        step(0, 0, 0, 0,   0, 0, 0,   0, 0, 0, z);
        D_IsMd = 1; MDU_Busy = 0;
        step(0, 0, 0, 0,   0, 0, 0,   0, 0, 0, z);
        D_IsMd = 0; MDU_Busy = 0;
`endif

        for (int i = 0; i < 5 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
